// File: rtl/fill_station_ctrl.sv
// Bottle fill-station controller: Moore FSM sequencing the conveyor, the fill
// valve, a per-bottle done pulse to sealing, and a tank/bottle alarm.
// Optional fill-timeout alarm is enabled by defining macro FILL_TIMEOUT_EN.
module fill_station_ctrl #(
   parameter int unsigned FILL_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       garrafa,
   input  logic       pos,
   input  logic       nivel,
   input  logic       reserva,
   input  logic       ack,
   output logic       motor,
   output logic       valvula,
   output logic       done,
   output logic       alarme,
   output logic [7:0] count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      DONE  = 3'd2,
      EXIT  = 3'd3,
      ALARM = 3'd4
   } state_t;

   state_t state;
   state_t state_next;
   logic   timeout_c;

   // Reject out-of-range timeout values at elaboration
   if (FILL_TIMEOUT < 2 || FILL_TIMEOUT > 255) begin : g_bad_timeout
      $error("fill_station_ctrl: FILL_TIMEOUT must be in 2..255");
   end

`ifdef FILL_TIMEOUT_EN
   localparam logic [7:0] TIMER_LAST = 8'(FILL_TIMEOUT - 1);

   logic [7:0] timer;

   // Fill timer: zero outside FILL, so every entry into FILL starts from 0
   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= 8'd0;
      end else if (state != FILL) begin
         timer <= 8'd0;
      end else begin
         timer <= timer + 8'd1;
      end
   end

   assign timeout_c = (state == FILL) && (timer == TIMER_LAST);
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!reserva)            state_next = ALARM;
            else if (garrafa && pos) state_next = FILL;
         end
         FILL: begin
            if (!reserva)            state_next = ALARM;
            else if (!garrafa)       state_next = ALARM;
            else if (nivel)          state_next = DONE;
            else if (timeout_c)      state_next = ALARM;
         end
         DONE: begin
            state_next = EXIT;
         end
         EXIT: begin
            if (!pos)                state_next = IDLE;
         end
         ALARM: begin
            if (ack && reserva) begin
               // Bottle still under the nozzle gets topped up
               state_next = (garrafa && pos) ? FILL : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered Moore outputs, decoded from the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         motor   <= 1'b1;
         valvula <= 1'b0;
         done    <= 1'b0;
         alarme  <= 1'b0;
      end else begin
         motor   <= (state_next == IDLE) || (state_next == EXIT);
         valvula <= (state_next == FILL);
         done    <= (state_next == DONE);
         alarme  <= (state_next == ALARM);
      end
   end

   // Filled-bottle counter, advances on the edge leaving DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 8'd0;
      end else if (state == DONE) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: tb/tb_fill_station_ctrl.sv
// Directed testbench for fill_station_ctrl (FILL_TIMEOUT = 10).
module tb_fill_station_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       garrafa;
   logic       pos;
   logic       nivel;
   logic       reserva;
   logic       ack;
   logic       motor;
   logic       valvula;
   logic       done;
   logic       alarme;
   logic [7:0] count;

   int errors = 0;
   int checks = 0;
   int exp_count = 0;

   fill_station_ctrl #(.FILL_TIMEOUT(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .garrafa (garrafa),
      .pos     (pos),
      .nivel   (nivel),
      .reserva (reserva),
      .ack     (ack),
      .motor   (motor),
      .valvula (valvula),
      .done    (done),
      .alarme  (alarme),
      .count   (count)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check all four state-decoded outputs at once
   task automatic outs(input string tag, input int m, input int v, input int d, input int a);
      check({tag, ".motor"},   int'(motor),   m);
      check({tag, ".valvula"}, int'(valvula), v);
      check({tag, ".done"},    int'(done),    d);
      check({tag, ".alarme"},  int'(alarme),  a);
   endtask

   // One complete bottle from IDLE back to IDLE
   task automatic fill_bottle();
      garrafa = 1'b1; pos = 1'b1; nivel = 1'b0;
      tick();                                    // FILL
      nivel = 1'b1;
      tick();                                    // DONE
      nivel = 1'b0; garrafa = 1'b0; pos = 1'b0;
      tick();                                    // EXIT
      tick();                                    // IDLE
      exp_count = (exp_count + 1) % 256;
   endtask

   // Valve and conveyor must never run together
   always @(negedge clk) begin
      if (reset === 1'b0) check("excl", int'(valvula & motor), 0);
   end

   initial begin
      reset = 1'b1; garrafa = 1'b0; pos = 1'b0; nivel = 1'b0;
      reserva = 1'b1; ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      outs("rst", 1, 0, 0, 0);
      check("rst.count", int'(count), 0);

      // Nominal fill: 5 FILL cycles, DONE, EXIT held while pos=1, IDLE
      garrafa = 1'b1; pos = 1'b1;
      tick();
      outs("nom.fill1", 0, 1, 0, 0);
      for (int i = 2; i <= 5; i++) tick();
      outs("nom.fill5", 0, 1, 0, 0);
      nivel = 1'b1;
      tick();
      outs("nom.done", 0, 0, 1, 0);
      check("nom.count_in_done", int'(count), 0);
      nivel = 1'b0;
      tick();
      outs("nom.exit", 1, 0, 0, 0);
      check("nom.count", int'(count), 1);
      tick();
      outs("nom.exit_hold", 1, 0, 0, 0);     // bottle still at pos: no refill
      pos = 1'b0; garrafa = 1'b0;
      tick();
      outs("nom.idle", 1, 0, 0, 0);
      exp_count = 1;

      // Bottle removed during FILL
      garrafa = 1'b1; pos = 1'b1;
      tick();
      outs("lost.fill", 0, 1, 0, 0);
      garrafa = 1'b0;
      tick();
      outs("lost.alarm", 0, 0, 0, 1);
      tick();
      outs("lost.hold", 0, 0, 0, 1);
      check("lost.count", int'(count), 1);
      ack = 1'b1; pos = 1'b0;
      tick();
      outs("lost.idle", 1, 0, 0, 0);
      ack = 1'b0;

      // Tank empties mid-fill, then top-up after acknowledge
      garrafa = 1'b1; pos = 1'b1;
      tick();
      outs("tank.fill", 0, 1, 0, 0);
      reserva = 1'b0;
      tick();
      outs("tank.alarm", 0, 0, 0, 1);
      ack = 1'b1;
      tick();
      outs("tank.ack_empty", 0, 0, 0, 1);
      ack = 1'b0; reserva = 1'b1;
      tick();
      outs("tank.no_ack", 0, 0, 0, 1);
      ack = 1'b1;
      tick();
      outs("tank.topup", 0, 1, 0, 0);
      ack = 1'b0; nivel = 1'b1;
      tick();
      outs("tank.done", 0, 0, 1, 0);
      nivel = 1'b0; garrafa = 1'b0; pos = 1'b0;
      tick();
      check("tank.count", int'(count), 2);
      tick();
      exp_count = 2;

      // Empty tank while idle goes straight to ALARM, ack without bottle -> IDLE
      reserva = 1'b0;
      tick();
      outs("idle_empty.alarm", 0, 0, 0, 1);
      reserva = 1'b1; ack = 1'b1;
      tick();
      outs("idle_empty.idle", 1, 0, 0, 0);
      ack = 1'b0;

`ifdef FILL_TIMEOUT_EN
      // Timeout after exactly 10 FILL cycles with nivel low
      garrafa = 1'b1; pos = 1'b1;
      for (int i = 1; i <= 10; i++) tick();
      outs("to.fill10", 0, 1, 0, 0);
      tick();
      outs("to.alarm", 0, 0, 0, 1);
      ack = 1'b1;
      tick();                                    // top-up: timer restarts
      ack = 1'b0;
      for (int i = 2; i <= 10; i++) tick();
      outs("to.refill10", 0, 1, 0, 0);
      nivel = 1'b1;                              // on the 10th cycle: DONE wins
      tick();
      outs("to.done", 0, 0, 1, 0);
`else
      // Without the timer FILL waits indefinitely for nivel
      garrafa = 1'b1; pos = 1'b1;
      for (int i = 1; i <= 30; i++) tick();
      outs("nto.fill30", 0, 1, 0, 0);
      nivel = 1'b1;
      tick();
      outs("nto.done", 0, 0, 1, 0);
`endif
      nivel = 1'b0; garrafa = 1'b0; pos = 1'b0;
      tick();
      check("to.count", int'(count), 3);
      tick();
      exp_count = 3;

      // Reset mid-FILL with count=7, then a reset glitch between edges
      while (exp_count != 7) fill_bottle();
      check("pre_rst.count", int'(count), 7);
      garrafa = 1'b1; pos = 1'b1;
      tick();
      outs("mid.fill", 0, 1, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      outs("mid.rst", 1, 0, 0, 0);
      check("mid.rst_count", int'(count), 0);
      exp_count = 0;
      tick();
      outs("mid.refill", 0, 1, 0, 0);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      outs("glitch.fill", 0, 1, 0, 0);
      garrafa = 1'b0; pos = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Counter wraps after 256 bottles
      for (int i = 0; i < 256; i++) fill_bottle();
      check("wrap.256", int'(count), 0);
      fill_bottle();
      check("wrap.257", int'(count), 1);
      check("wrap.model", int'(count), exp_count);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
